// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, constants, state enum and decode packet for the fetch front end
package fetch_unit_pkg;
   localparam int XLEN = 32;
   localparam int INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
   typedef enum logic {BOOT, RUN} fetch_state_e;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_pkt_t;
   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, DEPTH a power of two, payload type T.
// Ports: clk, rst_n (async low); flush clears contents; push/wdata write;
// pop/rdata read head; empty; count = occupancy.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter type T = logic [31:0]
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  T                           wdata,
   input  logic                       pop,
   output T                           rdata,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   T mem_q [DEPTH];
   T mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop && cnt_q != '0;
      do_push = push && (cnt_q != CW'(DEPTH) || do_pop);
      mem_d = mem_q;
      if (do_push) mem_d[wr_q] = wdata;
      wr_d = flush ? '0 : wr_q + AW'(do_push);
      rd_d = flush ? '0 : rd_q + AW'(do_pop);
      cnt_d = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) mem_q <= mem_d;
   assign rdata = mem_q[rd_q];
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && cnt_q == CW'(DEPTH) && !pop));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end; owns fetch PC, issues imem requests,
// handles redirects by dropping wrong-path responses, buffers responses for decode.
// Ports: clk, rst_n (async low); redirect_valid/redirect_pc from execute;
// imem_req_valid/ready/addr request channel; imem_rsp_valid/data response channel;
// if_valid/if_ready/if_pc/if_instr/if_pc_plus4 decode channel.
module fetch_unit import fetch_unit_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc_plus4
);
   localparam int CW = $clog2(DEPTH+1);
   fetch_state_e state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, tag_pc;
   logic [CW-1:0] discard_q, discard_d, inflight, buf_count;
   logic redir, req_fire, buf_push, tag_empty, buf_empty;
   if_pkt_t head, rsp_pkt;
   always_comb begin
      state_d = (state_q == BOOT) ? RUN : state_q;
      redir = state_q == RUN && redirect_valid;
      imem_req_valid = state_q == RUN && !redirect_valid && int'(inflight) + int'(buf_count) < DEPTH;
      req_fire = imem_req_valid && imem_req_ready;
      // a redirect-cycle response is always wrong-path, as is anything still owed by discard
      buf_push = imem_rsp_valid && !redir && discard_q == '0;
      fetch_pc_d = redir ? redirect_pc & ~32'h3 : req_fire ? pc_next(fetch_pc_q) : fetch_pc_q;
      discard_d = redir ? inflight - CW'(imem_rsp_valid)
                : (imem_rsp_valid && discard_q != '0) ? discard_q - 1'b1 : discard_q;
      rsp_pkt = '{pc: tag_pc, instr: imem_rsp_data};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         fetch_pc_q <= RESET_PC;
         discard_q <= '0;
      end else begin
         state_q <= state_d;
         fetch_pc_q <= fetch_pc_d;
         discard_q <= discard_d;
      end
   end
   // tag-queue occupancy is exactly the number of outstanding requests
   fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .push(req_fire), .wdata(fetch_pc_q),
      .pop(imem_rsp_valid), .rdata(tag_pc), .empty(tag_empty), .count(inflight)
   );
   fetch_fifo #(.DEPTH(DEPTH), .T(if_pkt_t)) u_buf (
      .clk(clk), .rst_n(rst_n), .flush(redir), .push(buf_push), .wdata(rsp_pkt),
      .pop(if_valid && if_ready), .rdata(head), .empty(buf_empty), .count(buf_count)
   );
   assign imem_req_addr = fetch_pc_q;
   assign if_valid = !buf_empty;
   assign if_pc = if_valid ? head.pc : '0;
   assign if_instr = if_valid ? head.instr : '0;
   assign if_pc_plus4 = if_valid ? pc_next(head.pc) : '0;
   a_credit: assert property (@(posedge clk) disable iff (!rst_n)
      int'(inflight) + int'(buf_count) <= DEPTH);
   a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && tag_empty));
endmodule
